// File: rtl/accelerator_deadlock_pkg.sv
// Shared FSM state encodings and index-width helper for the deadlock report unit.
package accelerator_deadlock_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t CONFIRM = 2'd1;
    localparam state_t REPORT  = 2'd2;
    localparam state_t HOLD    = 2'd3;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/accelerator_hls_deadlock_prio_enc.sv
// Lowest-set-bit priority encoder over the active monitor vector.
module accelerator_hls_deadlock_prio_enc
    import accelerator_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int IDX_W   = idx_w(NUM_MON)
) (
    input  logic [NUM_MON-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/accelerator_hls_deadlock_report_unit.sv
// Confirms persistent monitor blocks and emits one valid/ready deadlock report per event.
// ACCELERATOR_DEADLOCK_TIMESTAMP_EN builds the cycle counter; otherwise report_cycle is 0.
module accelerator_hls_deadlock_report_unit
    import accelerator_deadlock_pkg::*;
#(
    parameter int NUM_MON        = 4,
    parameter int IDX_W          = 2,
    parameter int CONFIRM_CYCLES = 16,
    parameter int TS_W           = 32,
    parameter int CNT_W          = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_in,
    input  logic [NUM_MON-1:0] mon_mask,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [TS_W-1:0]    report_cycle,
    output logic [CNT_W-1:0]   report_count,
    output logic               deadlock_flag
);

    localparam int CW = $clog2(CONFIRM_CYCLES + 1);

    logic [NUM_MON-1:0] act;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;

    assign act = block_in & mon_mask;

    accelerator_hls_deadlock_prio_enc #(
        .NUM_MON (NUM_MON),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .vec (act),
        .idx (enc_idx),
        .any (enc_any)
    );

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rep_idx_q, rep_idx_d;
    logic [CNT_W-1:0] evt_q, evt_d;
    logic             valid_q, valid_d;
    logic             flag_q, flag_d;
    logic             enter_report;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        rep_idx_d    = rep_idx_q;
        evt_d        = evt_q;
        valid_d      = valid_q;
        flag_d       = flag_q;
        enter_report = 1'b0;
        // clear wins over any capture or confirmation in the same cycle
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            flag_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc_any) begin
                        idx_d     = enc_idx;
                        rep_idx_d = enc_idx;
                        cnt_d     = CW'(1);
                        if (CONFIRM_CYCLES == 1) enter_report = 1'b1;
                        else                     state_d      = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (act[idx_q]) begin
                        cnt_d     = cnt_q + CW'(1);
                        rep_idx_d = idx_q;
                        if (cnt_q == CW'(CONFIRM_CYCLES - 1)) enter_report = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                REPORT: begin
                    if (report_ready) begin
                        state_d = HOLD;
                        valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
            if (enter_report) begin
                state_d = REPORT;
                valid_d = 1'b1;
                flag_d  = 1'b1;
                if (evt_q != '1) evt_d = evt_q + CNT_W'(1);
            end else begin
                rep_idx_d = rep_idx_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            rep_idx_q <= '0;
            evt_q     <= '0;
            valid_q   <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rep_idx_q <= rep_idx_d;
            evt_q     <= evt_d;
            valid_q   <= valid_d;
            flag_q    <= flag_d;
        end
    end

`ifdef ACCELERATOR_DEADLOCK_TIMESTAMP_EN
    logic [TS_W-1:0] cyc_q, cyc_d;
    logic [TS_W-1:0] rep_cyc_q, rep_cyc_d;

    always_comb begin
        cyc_d     = cyc_q + TS_W'(1);
        rep_cyc_d = (enter_report && !clear) ? cyc_q : rep_cyc_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q     <= '0;
            rep_cyc_q <= '0;
        end else begin
            cyc_q     <= cyc_d;
            rep_cyc_q <= rep_cyc_d;
        end
    end

    assign report_cycle = rep_cyc_q;
`else
    assign report_cycle = '0;
`endif

    assign report_valid  = valid_q;
    assign report_idx    = rep_idx_q;
    assign report_count  = evt_q;
    assign deadlock_flag = flag_q;

endmodule

// File: tb/tb_accelerator_hls_deadlock_report_unit.sv
// Directed self-checking bench for the deadlock report unit (NUM_MON=4, CONFIRM_CYCLES=16).
module tb_accelerator_hls_deadlock_report_unit;

    localparam int NUM_MON = 4;
    localparam int IDX_W   = 2;
    localparam int C       = 16;
    localparam int TS_W    = 32;
    localparam int CNT_W   = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic [NUM_MON-1:0] block_in;
    logic [NUM_MON-1:0] mon_mask;
    logic               clear;
    logic               report_valid;
    logic               report_ready;
    logic [IDX_W-1:0]   report_idx;
    logic [TS_W-1:0]    report_cycle;
    logic [CNT_W-1:0]   report_count;
    logic               deadlock_flag;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clock = ~clock;

    accelerator_hls_deadlock_report_unit #(
        .NUM_MON        (NUM_MON),
        .IDX_W          (IDX_W),
        .CONFIRM_CYCLES (C),
        .TS_W           (TS_W),
        .CNT_W          (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .block_in      (block_in),
        .mon_mask      (mon_mask),
        .clear         (clear),
        .report_valid  (report_valid),
        .report_ready  (report_ready),
        .report_idx    (report_idx),
        .report_cycle  (report_cycle),
        .report_count  (report_count),
        .deadlock_flag (deadlock_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Run n cycles and require report_valid to stay low throughout.
    task automatic quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (report_valid) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic check_report(input string tag, input int idx, input int cnt);
        check({tag, "_valid"}, report_valid, 1);
        check({tag, "_idx"}, report_idx, idx);
        check({tag, "_count"}, report_count, cnt);
        check({tag, "_flag"}, deadlock_flag, 1);
`ifndef ACCELERATOR_DEADLOCK_TIMESTAMP_EN
        check({tag, "_cycle"}, report_cycle, 0);
`endif
    endtask

    task automatic ack_and_clear();
        block_in     = '0;
        report_ready = 1'b1;
        step(1);
        report_ready = 1'b0;
        clear        = 1'b1;
        step(1);
        clear        = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        block_in     = '0;
        mon_mask     = '1;
        clear        = 1'b0;
        report_ready = 1'b0;
        step(3);
        check("rst_valid", report_valid, 0);
        check("rst_flag", deadlock_flag, 0);
        check("rst_count", report_count, 0);
        check("rst_idx", report_idx, 0);
        check("rst_cycle", report_cycle, 0);
        reset = 1'b0;
        step(2);

        // Basic confirmation on monitor 2: valid exactly after the 16th high sample.
        block_in = 4'b0100;
        quiet("t1_early", C - 1);
        step(1);
        check_report("t1", 2, 1);

        // Back-pressure: fields hold while ready is low.
        block_in = '0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_report("t4_stall", 2, 1);
        end
        report_ready = 1'b1;
        step(1);
        report_ready = 1'b0;
        check("t4_hs_valid", report_valid, 0);
        block_in = 4'b0001;
        quiet("t4_hold", 40);
        check("t4_hold_flag", deadlock_flag, 1);
        block_in = '0;
        clear    = 1'b1;
        step(1);
        clear    = 1'b0;
        check("t4_clr_flag", deadlock_flag, 0);
        check("t4_clr_count", report_count, 1);

        // Broken burst must not report; the following full burst does.
        block_in = 4'b0010;
        quiet("t2_burst1", C - 1);
        block_in = 4'b0000;
        quiet("t2_gap", 1);
        block_in = 4'b0010;
        quiet("t2_burst2", C - 1);
        step(1);
        check_report("t2", 1, 2);
        ack_and_clear();

        // Two monitors at once: lowest index wins.
        block_in = 4'b1010;
        quiet("t3_pair", C - 1);
        step(1);
        check_report("t3", 1, 3);
        ack_and_clear();

        // Masked monitor never reports.
        mon_mask = 4'b0111;
        block_in = 4'b1000;
        quiet("t3_masked", 100);
        check("t3_masked_flag", deadlock_flag, 0);
        block_in = '0;
        mon_mask = '1;
        step(1);

        // Clear while a report is pending, with the block still present.
        block_in = 4'b0001;
        quiet("t5_first", C - 1);
        step(1);
        check_report("t5_first", 0, 4);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t5_clr_valid", report_valid, 0);
        check("t5_clr_flag", deadlock_flag, 0);
        check("t5_clr_count", report_count, 4);
        quiet("t5_again", C - 1);
        step(1);
        check_report("t5_again", 0, 5);
        ack_and_clear();

        // Reset in the middle of a confirmation.
        block_in = 4'b0100;
        step(5);
        reset = 1'b1;
        step(1);
        check("t6_valid", report_valid, 0);
        check("t6_flag", deadlock_flag, 0);
        check("t6_count", report_count, 0);
        check("t6_idx", report_idx, 0);
        check("t6_cycle", report_cycle, 0);
        reset    = 1'b0;
        block_in = '0;
        step(2);

        // After reset the earlier partial burst is gone: a fresh burst reports count 1.
        block_in = 4'b1000;
        quiet("t6_post", C - 1);
        step(1);
        check_report("t6_post", 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
